// File: rtl/ctrl_fsm_112.sv
// Multi-cycle main controller for the MIPS-subset datapath: latches the
// fetched instruction, decodes it, sequences IF/ID/EX/MEM/WB, issues the
// PC commit strobe and keeps cycle/retire counters. Stops for good on HALT.
module ctrl_fsm_112 #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction,
  output logic             PCWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             ExtOp,
  output logic [2:0]       ALUCtr,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t      cur, nxt;
  logic [31:0] ir;
  logic [5:0]  op, funct;

  // Decoded instruction class and datapath controls (valid from ID onward)
  logic       is_r, is_alui, is_lw, is_sw, is_beq, is_j, is_halt, funct_ok;
  logic [2:0] dec_alu;
  logic       dec_src, dec_ext, dec_dst;

  // Register-field bits are consumed by the datapath, not by this controller
  logic       unused_ir_bits;

  assign op             = ir[31:26];
  assign funct          = ir[5:0];
  assign unused_ir_bits = ^ir[25:6];
  assign state          = cur;
  assign halted         = (cur == S_HALT);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IF;
    else     cur <= nxt;
  end

  // Instruction register loads on the edge that ends IF
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ir <= '0;
    else if (cur == S_IF) ir <= Instruction;
  end

  // Opcode/funct decode from the latched IR only
  always_comb begin
    is_r     = 1'b0;
    is_alui  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_j     = 1'b0;
    is_halt  = 1'b0;
    funct_ok = 1'b0;
    dec_alu  = 3'b000;
    dec_src  = 1'b0;
    dec_ext  = 1'b0;
    dec_dst  = 1'b0;
    case (op)
      OP_R: begin
        is_r     = 1'b1;
        dec_dst  = 1'b1;
        funct_ok = 1'b1;
        case (funct)
          6'b100001: dec_alu = 3'b000;
          6'b100011: dec_alu = 3'b001;
          6'b100100: dec_alu = 3'b010;
          6'b100101: dec_alu = 3'b011;
          6'b101010: dec_alu = 3'b100;
          default:   funct_ok = 1'b0;
        endcase
      end
      OP_ADDIU: begin is_alui = 1'b1; dec_src = 1'b1; dec_ext = 1'b1; end
      OP_ORI:   begin is_alui = 1'b1; dec_src = 1'b1; dec_alu = 3'b011; end
      OP_LUI:   begin is_alui = 1'b1; dec_src = 1'b1; dec_alu = 3'b101; end
      OP_LW:    begin is_lw = 1'b1; dec_src = 1'b1; dec_ext = 1'b1; end
      OP_SW:    begin is_sw = 1'b1; dec_src = 1'b1; dec_ext = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; dec_ext = 1'b1; dec_alu = 3'b001; end
      OP_J:     is_j = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  ;
    endcase
  end

  // Next-state and Moore outputs from state and IR
  always_comb begin
    nxt      = cur;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUCtr   = 3'b000;
    if (cur inside {S_ID, S_EX, S_MEM, S_WB}) begin
      ALUSrc = dec_src;
      ExtOp  = dec_ext;
      ALUCtr = dec_alu;
      RegDst = dec_dst;
    end
    case (cur)
      S_IF: begin
        // Reset holds state at IF, so the load strobe is masked explicitly
        IRWrite = ~rst;
        nxt     = S_ID;
      end
      S_ID: begin
        if (is_halt) begin
          nxt = S_HALT;
        end else if (is_r || is_alui || is_lw || is_sw || is_beq) begin
          nxt = S_EX;
        end else begin
          // j and anything unrecognised commit straight from decode
          PCWrite = 1'b1;
          Jump    = is_j;
          nxt     = S_IF;
        end
      end
      S_EX: begin
        if (is_beq) begin
          PCWrite = 1'b1;
          Branch  = 1'b1;
          nxt     = S_IF;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (is_sw) begin
          PCWrite = 1'b1;
          nxt     = S_IF;
        end else begin
          nxt = S_WB;
        end
      end
      S_WB: begin
        PCWrite  = 1'b1;
        RegWrite = is_lw || is_alui || (is_r && funct_ok);
        MemtoReg = is_lw;
        nxt      = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  // Free-running cycle counter (frozen in HALT) and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      retired <= '0;
    end else begin
      if (cur != S_HALT) cycles  <= cycles + CNT_W'(1);
      if (PCWrite)       retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_112.sv
// Directed bench for ctrl_fsm_112: walks each instruction class cycle by
// cycle against hand-computed output vectors and counter values.
module tb_ctrl_fsm_112;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instruction;
  logic        PCWrite, Branch, Jump, IRWrite, RegWrite, RegDst;
  logic        MemRead, MemWrite, MemtoReg, ALUSrc, ExtOp, halted;
  logic [2:0]  ALUCtr, state;
  logic [31:0] cycles, retired;
  logic [17:0] outs;

  int errors = 0;
  int checks = 0;

  ctrl_fsm_112 #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Instruction(Instruction),
    .PCWrite(PCWrite), .Branch(Branch), .Jump(Jump), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
    .ExtOp(ExtOp), .ALUCtr(ALUCtr), .state(state), .halted(halted),
    .cycles(cycles), .retired(retired)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, Branch, Jump, IRWrite, RegWrite, RegDst, MemRead,
                 MemWrite, MemtoReg, ALUSrc, ExtOp, ALUCtr, state, halted};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Field order: pcw br jmp irw rw rd mr mw m2r asrc ext alu st halted
  task automatic exp_o(input string tag,
                       input logic pcw, br, jmp, irw, rw, rd, mr, mw, m2r, asrc, ext,
                       input logic [2:0] alu, st, input logic h);
    logic [17:0] e;
    e = {pcw, br, jmp, irw, rw, rd, mr, mw, m2r, asrc, ext, alu, st, h};
    chk(tag, 64'(outs), 64'(e));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // IF cycle: present the next word before the edge that latches it
  task automatic fetch(input string tag, input logic [31:0] word);
    Instruction = word;
    exp_o(tag, 0,0,0,1,0,0,0,0,0,0,0, 3'd0, 3'd0, 0);
    step();
  endtask

  task automatic counters(input string tag, input int cyc, input int ret);
    chk({tag, ".cycles"},  64'(cycles),  64'(cyc));
    chk({tag, ".retired"}, 64'(retired), 64'(ret));
  endtask

  initial begin
    rst = 1'b1;
    Instruction = 32'h0;
    repeat (2) @(negedge clk);
    exp_o("reset.outs", 0,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 0);
    counters("reset", 0, 0);
    rst = 1'b0;
    #1;

    // j 0x08000004
    fetch("j.if", 32'h0800_0004);
    exp_o("j.id", 1,0,1,0,0,0,0,0,0,0,0, 3'd0, 3'd1, 0);
    step();
    counters("j.done", 2, 1);

    // addu $3,$1,$2
    fetch("addu.if", 32'h0022_1821);
    exp_o("addu.id", 0,0,0,0,0,1,0,0,0,0,0, 3'd0, 3'd1, 0); step();
    exp_o("addu.ex", 0,0,0,0,0,1,0,0,0,0,0, 3'd0, 3'd2, 0); step();
    exp_o("addu.wb", 1,0,0,0,1,1,0,0,0,0,0, 3'd0, 3'd4, 0); step();
    counters("addu.done", 6, 2);

    // lw $2,8($1)
    fetch("lw.if", 32'h8C22_0008);
    exp_o("lw.id",  0,0,0,0,0,0,0,0,0,1,1, 3'd0, 3'd1, 0); step();
    exp_o("lw.ex",  0,0,0,0,0,0,0,0,0,1,1, 3'd0, 3'd2, 0); step();
    exp_o("lw.mem", 0,0,0,0,0,0,1,0,0,1,1, 3'd0, 3'd3, 0); step();
    exp_o("lw.wb",  1,0,0,0,1,0,0,0,1,1,1, 3'd0, 3'd4, 0); step();

    // sw $2,12($1)
    fetch("sw.if", 32'hAC22_000C);
    exp_o("sw.id",  0,0,0,0,0,0,0,0,0,1,1, 3'd0, 3'd1, 0); step();
    exp_o("sw.ex",  0,0,0,0,0,0,0,0,0,1,1, 3'd0, 3'd2, 0); step();
    exp_o("sw.mem", 1,0,0,0,0,0,0,1,0,1,1, 3'd0, 3'd3, 0); step();
    counters("lwsw.done", 15, 4);

    // beq with the fetch bus scribbled after IF
    fetch("beq.if", 32'h1022_0003);
    Instruction = 32'hFFFF_FFFF;
    exp_o("beq.id", 0,0,0,0,0,0,0,0,0,0,1, 3'd1, 3'd1, 0); step();
    exp_o("beq.ex", 1,1,0,0,0,0,0,0,0,0,1, 3'd1, 3'd2, 0); step();
    counters("beq.done", 18, 5);

    // ori then HALT
    fetch("ori.if", 32'h3422_0F0F);
    exp_o("ori.id", 0,0,0,0,0,0,0,0,0,1,0, 3'd3, 3'd1, 0); step();
    exp_o("ori.ex", 0,0,0,0,0,0,0,0,0,1,0, 3'd3, 3'd2, 0); step();
    exp_o("ori.wb", 1,0,0,0,1,0,0,0,0,1,0, 3'd3, 3'd4, 0); step();
    fetch("halt.if", 32'hFC00_0000);
    exp_o("halt.id", 0,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd1, 0); step();
    exp_o("halt.st", 0,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd7, 1);
    counters("halt.enter", 24, 6);
    Instruction = 32'h0800_0000;
    repeat (10) step();
    exp_o("halt.stay", 0,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd7, 1);
    counters("halt.frozen", 24, 6);

    // Leave HALT through reset, then abort a lw in MEM
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    counters("rst2", 0, 0);
    fetch("abort.if", 32'h8C22_0008);
    step();
    step();
    exp_o("abort.mem", 0,0,0,0,0,0,1,0,0,1,1, 3'd0, 3'd3, 0);
    rst = 1'b1;
    #1;
    exp_o("abort.rst", 0,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 0);
    counters("abort.rst", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    counters("abort.rel", 0, 0);

    // Unsupported R-type funct: full sequence but no register write
    fetch("badr.if", 32'h0022_1820);
    exp_o("badr.id", 0,0,0,0,0,1,0,0,0,0,0, 3'd0, 3'd1, 0); step();
    exp_o("badr.ex", 0,0,0,0,0,1,0,0,0,0,0, 3'd0, 3'd2, 0); step();
    exp_o("badr.wb", 1,0,0,0,0,1,0,0,0,0,0, 3'd0, 3'd4, 0); step();

    // Unknown opcode behaves as NOP
    fetch("nop.if", 32'h2022_0001);
    exp_o("nop.id", 1,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd1, 0); step();

    // lui
    fetch("lui.if", 32'h3C01_1234);
    exp_o("lui.id", 0,0,0,0,0,0,0,0,0,1,0, 3'd5, 3'd1, 0); step();
    exp_o("lui.ex", 0,0,0,0,0,0,0,0,0,1,0, 3'd5, 3'd2, 0); step();
    exp_o("lui.wb", 1,0,0,0,1,0,0,0,0,1,0, 3'd5, 3'd4, 0); step();
    exp_o("lui.next", 0,0,0,1,0,0,0,0,0,0,0, 3'd0, 3'd0, 0);
    counters("final", 10, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
